// File: rtl/elevator_plant_if.sv
// Controller <-> plant signal bundle for the elevator car/shaft/door model.
// master = controller (or bench) side, slave = plant side.
interface elevator_plant_if;
  logic       door;          // 1=open, 0=close
  logic [1:0] direction;     // 00 idle, 01 up, 10 down, 11 idle
  logic       obstruct;      // door path blocked
  logic [1:0] FS;            // floor sensor, 0 = between floors
  logic       DC;            // door fully closed
  logic       door_open;     // door fully open
  logic [1:0] floor;         // last/current floor 1..3
  logic       interlock_err; // sticky: open commanded while moving
  logic       limit_err;     // sticky: travel past end floor commanded

  modport master (
    output door, direction, obstruct,
    input  FS, DC, door_open, floor, interlock_err, limit_err
  );

  modport slave (
    input  door, direction, obstruct,
    output FS, DC, door_open, floor, interlock_err, limit_err
  );
endinterface

// File: rtl/elevator_plant.sv
// Plant model of an elevator car, shaft and door. Responds to the
// controller's door/direction commands with floor-sensor and door-closed
// feedback, and flags interlock / end-of-shaft violations.
module elevator_plant #(
  parameter int TRAVEL_CYCLES = 20,
  parameter int DOOR_CYCLES   = 8,
  parameter int START_FLOOR   = 1
) (
  input  logic             clk,
  input  logic             rst,
  elevator_plant_if.slave  bus
);

  localparam int DW = (DOOR_CYCLES   > 2) ? $clog2(DOOR_CYCLES)   : 1;
  localparam int TW = (TRAVEL_CYCLES > 2) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam logic [DW-1:0] DLOAD = DW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] TLOAD = TW'(TRAVEL_CYCLES - 1);

  typedef enum logic [1:0] {D_CLOSED, D_OPENING, D_OPEN, D_CLOSING} dstate_t;
  typedef enum logic [1:0] {M_PARKED, M_UP, M_DOWN} mstate_t;

  dstate_t       d_st, d_nxt;
  mstate_t       m_st, m_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic [TW-1:0] mcnt, mcnt_nxt;
  logic [1:0]    flr, flr_nxt, fs, fs_nxt;
  logic          dc_q, dopen_q, ilk_q, lim_q;
  logic          ilk_set, lim_set;
  logic          cmd_up, cmd_dn;

  assign cmd_up = (bus.direction == 2'b01);
  assign cmd_dn = (bus.direction == 2'b10);

  // Door FSM next-state: the door may only start opening while parked;
  // an obstruction blocks any closing motion, including aborting an opening
  // stroke, so a blocked door always ends up fully open.
  always_comb begin
    d_nxt    = d_st;
    dcnt_nxt = dcnt;
    ilk_set  = 1'b0;
    case (d_st)
      D_CLOSED: begin
        if (bus.door) begin
          if (m_st == M_PARKED) begin
            d_nxt    = D_OPENING;
            dcnt_nxt = DLOAD;
          end else begin
            ilk_set = 1'b1;
          end
        end
      end
      D_OPENING: begin
        if (!bus.door && !bus.obstruct) begin
          d_nxt    = D_CLOSING;
          dcnt_nxt = DLOAD;
        end else if (dcnt == '0) begin
          d_nxt = D_OPEN;
        end else begin
          dcnt_nxt = dcnt - DW'(1);
        end
      end
      D_OPEN: begin
        if (!bus.door && !bus.obstruct) begin
          d_nxt    = D_CLOSING;
          dcnt_nxt = DLOAD;
        end
      end
      D_CLOSING: begin
        if (bus.door || bus.obstruct) begin
          d_nxt    = D_OPENING;
          dcnt_nxt = DLOAD;
        end else if (dcnt == '0) begin
          d_nxt = D_CLOSED;
        end else begin
          dcnt_nxt = dcnt - DW'(1);
        end
      end
      default: d_nxt = D_CLOSED;
    endcase
  end

  // Motion FSM next-state: departs only parked with the door closed; a
  // simultaneous open request takes precedence over departure. A segment
  // always completes regardless of later direction changes.
  always_comb begin
    m_nxt    = m_st;
    mcnt_nxt = mcnt;
    flr_nxt  = flr;
    fs_nxt   = fs;
    lim_set  = 1'b0;
    case (m_st)
      M_PARKED: begin
        if (d_st == D_CLOSED) begin
          if (cmd_up) begin
            if (flr == 2'd3)   lim_set = 1'b1;
            else if (!bus.door) begin
              m_nxt    = M_UP;
              mcnt_nxt = TLOAD;
              fs_nxt   = 2'd0;
            end
          end else if (cmd_dn) begin
            if (flr == 2'd1)   lim_set = 1'b1;
            else if (!bus.door) begin
              m_nxt    = M_DOWN;
              mcnt_nxt = TLOAD;
              fs_nxt   = 2'd0;
            end
          end
        end
      end
      M_UP, M_DOWN: begin
        if (mcnt == '0) begin
          flr_nxt = (m_st == M_UP) ? flr + 2'd1 : flr - 2'd1;
          fs_nxt  = flr_nxt;
          m_nxt   = M_PARKED;
        end else begin
          mcnt_nxt = mcnt - TW'(1);
        end
      end
      default: m_nxt = M_PARKED;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_st    <= D_CLOSED;
      m_st    <= M_PARKED;
      dcnt    <= '0;
      mcnt    <= '0;
      flr     <= 2'(START_FLOOR);
      fs      <= 2'(START_FLOOR);
      dc_q    <= 1'b1;
      dopen_q <= 1'b0;
      ilk_q   <= 1'b0;
      lim_q   <= 1'b0;
    end else begin
      d_st    <= d_nxt;
      m_st    <= m_nxt;
      dcnt    <= dcnt_nxt;
      mcnt    <= mcnt_nxt;
      flr     <= flr_nxt;
      fs      <= fs_nxt;
      dc_q    <= (d_nxt == D_CLOSED);
      dopen_q <= (d_nxt == D_OPEN);
      ilk_q   <= ilk_q | ilk_set;
      lim_q   <= lim_q | lim_set;
    end
  end

  assign bus.FS            = fs;
  assign bus.floor         = flr;
  assign bus.DC            = dc_q;
  assign bus.door_open     = dopen_q;
  assign bus.interlock_err = ilk_q;
  assign bus.limit_err     = lim_q;

endmodule
